// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package bin_to_bcd_seq_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Shift-and-add-3: a digit at or above 5 would carry past 9 after the
  // next left shift, so it is pre-corrected by adding 3.
  localparam bit [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam bit [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_CONV,
    BCD_DONE
  } bcd_state_t;

  // 10**n, used to check at elaboration that DIGITS can hold 2**BIN_W-1.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit's add-3 correction ahead of a left shift.
// Latency: purely combinational.
// Backpressure: none.
// Ports: digit_in - current BCD digit; digit_out - digit, +3 if it is >= 5.
module bcd_dabble_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? digit_in + BCD_ADJ_ADD
                                                  : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
// Latency: out_valid high BIN_W+1 cycles after acceptance; accepts every BIN_W+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_bin input handshake;
//        out_valid/out_ready/out_bcd result handshake, digit i at [4*i+3:4*i];
//        out_blank leading-zero mask, only when BCD_BLANK_EN is defined.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     out_blank,
`endif
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The largest input must fit: reject configurations where 10**DIGITS
  // does not exceed 2**BIN_W-1.
  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_width_err
    $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  bcd_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     bin_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [4*DIGITS-1:0]  out_bcd_q;

  logic [4*DIGITS-1:0]  adj_bcd;
  logic [4*DIGITS-1:0]  sh_bcd;
  logic [BIN_W-1:0]     sh_bin;
  logic                 sh_unused_msb;
  logic                 last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    bcd_dabble_digit u_dabble (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (adj_bcd[4*g +: 4])
    );
  end

  // {bcd,bin} shifted left by one after correction; the MSB of the top
  // digit is always 0 for legal widths and simply falls off.
  assign {sh_unused_msb, sh_bcd, sh_bin} = {adj_bcd, bin_q, 1'b0};

  // The final shift and the output register load happen on the same edge.
  assign last_shift = (state == BCD_CONV) && (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BCD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      BCD_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BCD_CONV;
      end
      BCD_CONV: begin
        if (last_shift) state_nxt = BCD_DONE;
      end
      BCD_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = BCD_IDLE;
      end
      default: state_nxt = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      out_bcd_q <= '0;
    end else begin
      case (state)
        BCD_IDLE: begin
          if (in_valid) begin
            bin_q <= in_bin;
            bcd_q <= '0;
            cnt   <= CNT_LOAD;
          end
        end
        BCD_CONV: begin
          bin_q <= sh_bin;
          bcd_q <= sh_bcd;
          cnt   <= cnt - CNT_ONE;
          if (last_shift) out_bcd_q <= sh_bcd;
        end
        default: ;
      endcase
    end
  end

  assign out_bcd = out_bcd_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] out_blank_q;
  logic              hi_zero;

  // Digit i blanks when it and every digit above it are zero; digit 0
  // never blanks so a zero value still shows one "0".
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (sh_bcd[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_blank_q <= '0;
    end else if (last_shift) begin
      out_blank_q <= blank_nxt;
    end
  end

  assign out_blank = out_blank_q;
`endif

endmodule
